rhd_cmd_sequencer: RTL and testbench
====================================

Name: rhd_cmd_sequencer

Overview:
Upstream command source for rhd_spi_master. On each sample tick it issues one frame of RHD2000 commands: one CONVERT per channel, then one auxiliary READ. Each command is presented on spi_data_in with a one-cycle spi_start pulse, and the next command waits for the master's spi_done. Per-command tags (channel index, convert flag) feed the downstream MISO sample aligner.

Parameters:
NUM_CHANNELS, 32, CONVERT commands per frame (1..64); channels 0..NUM_CHANNELS-1 in order.
INTER_CMD_GAP, 2, idle clk cycles between spi_done and the next spi_start (0..255).

Ports:
clk  input  1  system clock (112 MHz nominal).
rstn  input  1  asynchronous active-low reset.
enable  input  1  level; when low, no new frame starts.
frame_tick  input  1  one-cycle pulse; starts a frame.
fast_settle  input  1  H bit for the frame's CONVERTs, sampled at frame start.
aux_reg_addr  input  6  register for the frame's aux READ, sampled at frame start.
spi_start  output  1  one-cycle pulse to rhd_spi_master start.
spi_data_in  output  32  to rhd_spi_master data_in; {cmd[15:0], 16'h0000}.
spi_done  input  1  one-cycle pulse from the master when the current command completes.
cmd_channel  output  6  channel of the issued CONVERT; aux slot reports 6'd63.
cmd_is_convert  output  1  1 for a CONVERT slot, 0 otherwise.
frame_busy  output  1  high from frame start until the last command's spi_done.
frame_overrun  output  1  sticky; set when frame_tick arrives while frame_busy.
overrun_clr  input  1  one-cycle clear of frame_overrun.

Behaviour:
- Reset values: spi_start=0, spi_data_in=0, cmd_channel=0, cmd_is_convert=0, frame_busy=0, frame_overrun=0. Reset asserted mid-frame aborts the frame immediately; no further spi_start is issued.
- Command encodings:
  - CONVERT(c,H) = {2'b00, c[5:0], 7'b0, H}.
  - READ(r) = {2'b11, r[5:0], 8'h00}.
  - CALIBRATE = 16'h5500.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE: on frame_tick && enable:
  - latch fast_settle and aux_reg_addr;
  - slot counter <= 0; frame_busy <= 1; go to ISSUE.
- ISSUE: for one cycle, spi_start=1 with spi_data_in, cmd_channel and cmd_is_convert valid. Go to WAIT_DONE.
  - Latency: frame_tick at cycle T gives spi_start at T+1.
- Outputs hold: spi_data_in, cmd_channel and cmd_is_convert stay stable from ISSUE until the next ISSUE.
- WAIT_DONE: on spi_done:
  - if last slot: frame_busy <= 0 at the next edge; go to IDLE;
  - else: slot++; go to GAP (or straight to ISSUE if INTER_CMD_GAP=0).
- GAP: count INTER_CMD_GAP cycles, then go to ISSUE.
  - spi_done at cycle D gives the next spi_start at D+1+INTER_CMD_GAP.
- Slot order: 0..NUM_CHANNELS-1 are CONVERT(slot, H); slot NUM_CHANNELS is READ(aux_reg_addr). A frame has NUM_CHANNELS+1 commands.
- Input rules:
  - spi_done outside WAIT_DONE is ignored.
  - frame_tick while frame_busy: tick dropped, frame_overrun <= 1.
  - Same-cycle overrun set and overrun_clr: set wins.
  - enable deasserted mid-frame: the current frame completes; the next tick is ignored.
  - frame_tick in the same cycle the final spi_done returns to IDLE: counts as overrun and is dropped.
  - fast_settle and aux_reg_addr changes mid-frame do not affect the current frame.

Optional Feature:
RHD_CALIBRATE_EN:
- Defined:
  - Adds state CAL and an internal cal_pending flag, set by reset and by each rising edge of enable.
  - The first frame after cal_pending is set is prefixed with CALIBRATE plus 9 dummy READ(63), with cmd_channel=63 and cmd_is_convert=0.
  - That frame is therefore NUM_CHANNELS+11 commands; cal_pending clears when it starts.
- Not defined: no CAL state; every frame is NUM_CHANNELS+1 commands.

Test Plan:
- Basic frame: NUM_CHANNELS=4, INTER_CMD_GAP=2, auto-responder pulses spi_done 10 cycles after spi_start; frame_tick, fast_settle=0, aux=40 -> data words 0x0000_0000, 0x0100_0000, 0x0200_0000, 0x0300_0000, 0x E800_0000; cmd_channel 0,1,2,3,63; consecutive spi_start 13 cycles apart; frame_busy drops after the 5th done.
- fast_settle=1 at tick, toggled to 0 mid-frame -> all 4 CONVERT words have bit16=1 (e.g. 0x0201_0000).
- Overrun: second frame_tick 20 cycles after the first -> no extra spi_start, frame_overrun=1 and sticky until overrun_clr; same-cycle tick and clr -> stays 1.
- Reset mid-frame: rstn low after the 2nd spi_start -> all outputs at reset values, no spi_start until the next tick post-reset; the next frame starts at channel 0.
- enable=0 with ticks -> zero spi_start; enable dropped mid-frame -> frame completes all 5 commands.
- RHD_CALIBRATE_EN defined: first tick after reset -> 0x5500_0000 then 9 x 0xFF00_0000, then the 4 CONVERTs and the READ; the second frame has no calibrate; toggling enable 0->1 repeats the prefix.

Source files
------------

// File: rtl/rhd_cmd_sequencer.sv
// RHD2000 command sequencer: issues one frame of CONVERT commands plus an aux READ per frame tick.
// Optional calibration prefix (CALIBRATE + 9 dummy READs) is enabled by defining RHD_CALIBRATE_EN.
module rhd_cmd_sequencer #(
  parameter int NUM_CHANNELS  = 32,
  parameter int INTER_CMD_GAP = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic        fast_settle,
  input  logic [5:0]  aux_reg_addr,
  output logic        spi_start,
  output logic [31:0] spi_data_in,
  input  logic        spi_done,
  output logic [5:0]  cmd_channel,
  output logic        cmd_is_convert,
  output logic        frame_busy,
  output logic        frame_overrun,
  input  logic        overrun_clr
);

  localparam logic [6:0]  LAST_SLOT     = 7'(NUM_CHANNELS);
  localparam logic [7:0]  GAP_LAST      = (INTER_CMD_GAP == 0) ? 8'd0 : 8'(INTER_CMD_GAP - 1);
  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [5:0]  AUX_CHANNEL   = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef RHD_CALIBRATE_EN
    ST_CAL   = 3'd4,
`endif
    ST_GAP   = 3'd3
  } state_e;

  function automatic logic [15:0] cmd_convert(input logic [5:0] chan, input logic h);
    return {2'b00, chan, 7'b0000000, h};
  endfunction

  function automatic logic [15:0] cmd_read(input logic [5:0] reg_addr);
    return {2'b11, reg_addr, 8'h00};
  endfunction

  state_e      state_q, state_d, tgt_s;
  logic [6:0]  slot_q, slot_d;
  logic [7:0]  gap_q, gap_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        h_q, h_d;
  logic [5:0]  aux_q, aux_d;
  logic        start_q, start_d;
  logic [15:0] data_q, data_d;
  logic [5:0]  chan_q, chan_d;
  logic        conv_q, conv_d;
  logic        last_s;
`ifdef RHD_CALIBRATE_EN
  logic        cal_pending_q, cal_pending_d;
  logic        in_cal_q, in_cal_d;
  logic [3:0]  cal_idx_q, cal_idx_d;
  logic        enable_q;
  logic        rise_s;
  localparam logic [3:0] CAL_LAST = 4'd9;

  assign rise_s = enable & ~enable_q;
  assign last_s = (slot_q == LAST_SLOT) && !in_cal_q;
`else
  assign last_s = (slot_q == LAST_SLOT);
`endif

  assign spi_start      = start_q;
  assign spi_data_in    = {data_q, 16'h0000};
  assign cmd_channel    = chan_q;
  assign cmd_is_convert = conv_q;
  assign frame_busy     = busy_q;
  assign frame_overrun  = overrun_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      slot_q    <= 7'd0;
      gap_q     <= 8'd0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      h_q       <= 1'b0;
      aux_q     <= 6'd0;
      start_q   <= 1'b0;
      data_q    <= 16'h0000;
      chan_q    <= 6'd0;
      conv_q    <= 1'b0;
`ifdef RHD_CALIBRATE_EN
      cal_pending_q <= 1'b1;
      in_cal_q      <= 1'b0;
      cal_idx_q     <= 4'd0;
      enable_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      gap_q     <= gap_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      h_q       <= h_d;
      aux_q     <= aux_d;
      start_q   <= start_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
      conv_q    <= conv_d;
`ifdef RHD_CALIBRATE_EN
      cal_pending_q <= cal_pending_d;
      in_cal_q      <= in_cal_d;
      cal_idx_q     <= cal_idx_d;
      enable_q      <= enable;
`endif
    end
  end

  // Next-state, slot/gap counters and frame flags
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    h_d     = h_q;
    aux_d   = aux_q;
    tgt_s   = ST_ISSUE;
`ifdef RHD_CALIBRATE_EN
    in_cal_d      = in_cal_q;
    cal_idx_d     = cal_idx_q;
    cal_pending_d = cal_pending_q | rise_s;
`endif
    // A tick while busy (including the final-done cycle) is an overrun; set beats clear
    if (frame_tick && busy_q) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && enable) begin
          h_d    = fast_settle;
          aux_d  = aux_reg_addr;
          slot_d = 7'd0;
          gap_d  = 8'd0;
          busy_d = 1'b1;
`ifdef RHD_CALIBRATE_EN
          if (cal_pending_q || rise_s) begin
            state_d       = ST_CAL;
            in_cal_d      = 1'b1;
            cal_idx_d     = 4'd0;
            cal_pending_d = 1'b0;
          end else begin
            state_d  = ST_ISSUE;
            in_cal_d = 1'b0;
          end
`else
          state_d = ST_ISSUE;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
`ifdef RHD_CALIBRATE_EN
      ST_CAL:   state_d = ST_WAIT;
`endif
      ST_WAIT: begin
        if (spi_done) begin
          if (last_s) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            gap_d = 8'd0;
`ifdef RHD_CALIBRATE_EN
            if (in_cal_q) begin
              if (cal_idx_q == CAL_LAST) begin
                in_cal_d = 1'b0;
                tgt_s    = ST_ISSUE;
              end else begin
                cal_idx_d = cal_idx_q + 4'd1;
                tgt_s     = ST_CAL;
              end
            end else begin
              slot_d = slot_q + 7'd1;
            end
`else
            slot_d = slot_q + 7'd1;
`endif
            if (INTER_CMD_GAP == 0) begin
              state_d = tgt_s;
            end else begin
              state_d = ST_GAP;
            end
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
`ifdef RHD_CALIBRATE_EN
          state_d = in_cal_q ? ST_CAL : ST_ISSUE;
`else
          state_d = ST_ISSUE;
`endif
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output word/tags are loaded only when entering an issue state, otherwise held
  always_comb begin
    start_d = 1'b0;
    data_d  = data_q;
    chan_d  = chan_q;
    conv_d  = conv_q;
`ifdef RHD_CALIBRATE_EN
    if (state_d == ST_CAL) begin
      start_d = 1'b1;
      chan_d  = AUX_CHANNEL;
      conv_d  = 1'b0;
      if (cal_idx_d == 4'd0) begin
        data_d = CMD_CALIBRATE;
      end else begin
        data_d = cmd_read(AUX_CHANNEL);
      end
    end else
`endif
    if (state_d == ST_ISSUE) begin
      start_d = 1'b1;
      if (slot_d < LAST_SLOT) begin
        data_d = cmd_convert(slot_d[5:0], h_d);
        chan_d = slot_d[5:0];
        conv_d = 1'b1;
      end else begin
        data_d = cmd_read(aux_d);
        chan_d = AUX_CHANNEL;
        conv_d = 1'b0;
      end
    end else begin
      start_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_rhd_cmd_sequencer.sv
// Directed + randomized bench for rhd_cmd_sequencer with an auto-responding SPI master model.
// Expected command lists are built from the RHD2000 encoding rules; honours RHD_CALIBRATE_EN.
module tb_rhd_cmd_sequencer;
  localparam int NCH = 4;
  localparam int GAP = 2;
`ifdef RHD_CALIBRATE_EN
  localparam bit CAL_ON = 1'b1;
`else
  localparam bit CAL_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] word;
    logic [5:0]  chan;
    logic        conv;
    int          at;
    int          lat;
  } cmd_t;

  logic clk = 1'b0, rstn = 1'b0, enable = 1'b0, frame_tick = 1'b0, fast_settle = 1'b0;
  logic overrun_clr = 1'b0, resp_done = 1'b0, extra_done = 1'b0;
  logic [5:0] aux_reg_addr = 6'd0;
  logic spi_start, spi_done, cmd_is_convert, frame_busy, frame_overrun;
  logic [31:0] spi_data_in;
  logic [5:0] cmd_channel;

  int total = 0, bad = 0, cyc = 0, lat_fix = 10;
  cmd_t obs_q[$];
  cmd_t exp_q[$];
  bit cal_pend = 1'b0;
  bit cur_h, cur_cal;
  logic [5:0] cur_aux;
  int cur_tick, idle_cyc;

  assign spi_done = resp_done | extra_done;

  rhd_cmd_sequencer #(.NUM_CHANNELS(NCH), .INTER_CMD_GAP(GAP)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .frame_tick(frame_tick),
    .fast_settle(fast_settle), .aux_reg_addr(aux_reg_addr), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_done(spi_done), .cmd_channel(cmd_channel),
    .cmd_is_convert(cmd_is_convert), .frame_busy(frame_busy),
    .frame_overrun(frame_overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI master model: logs each start, answers with spi_done after lat cycles
  initial begin
    int pending;
    int lat;
    pending = 0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (!rstn) begin
        pending = 0;
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          resp_done = 1'b1;
          if (obs_q.size() > 0) chk("hold_word", spi_data_in, obs_q[$].word);
        end
      end else if (spi_start) begin
        lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(12, 1));
        pending = lat;
        obs_q.push_back('{spi_data_in, cmd_channel, cmd_is_convert, cyc, lat});
      end
    end
  end

  function automatic int exp_len();
    return NCH + 1 + (cur_cal ? 10 : 0);
  endfunction

  task automatic build_exp();
    exp_q.delete();
    if (cur_cal) begin
      exp_q.push_back('{32'h5500_0000, 6'd63, 1'b0, 0, 0});
      for (int i = 0; i < 9; i++) exp_q.push_back('{32'hFF00_0000, 6'd63, 1'b0, 0, 0});
    end
    for (int c = 0; c < NCH; c++)
      exp_q.push_back('{(32'(c) << 24) | (32'(cur_h) << 16), 6'(c), 1'b1, 0, 0});
    exp_q.push_back('{32'hC000_0000 | (32'(cur_aux) << 24), 6'd63, 1'b0, 0, 0});
  endtask

  task automatic start_frame(input bit h, input logic [5:0] aux);
    obs_q.delete();
    cur_h = h;
    cur_aux = aux;
    cur_cal = CAL_ON && cal_pend;
    cal_pend = 1'b0;
    @(negedge clk);
    fast_settle = h;
    aux_reg_addr = aux;
    frame_tick = 1'b1;
    cur_tick = cyc;
    @(negedge clk);
    frame_tick = 1'b0;
    fast_settle = ~h;
    aux_reg_addr = ~aux;
    chk("busy_set", frame_busy, 1'b1);
  endtask

  task automatic finish_frame();
    int n;
    n = 0;
    while (frame_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    idle_cyc = cyc;
    chk("frame_timeout", n < 3000, 1'b1);
    build_exp();
    chk("cmd_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("word[%0d]", i), obs_q[i].word, exp_q[i].word);
      chk($sformatf("chan[%0d]", i), obs_q[i].chan, exp_q[i].chan);
      chk($sformatf("conv[%0d]", i), obs_q[i].conv, exp_q[i].conv);
      if (i == 0) chk("tick_latency", obs_q[0].at, cur_tick + 1);
      else chk($sformatf("spacing[%0d]", i), obs_q[i].at - obs_q[i-1].at, obs_q[i-1].lat + 1 + GAP);
    end
    if (obs_q.size() > 0) chk("busy_drop", idle_cyc, obs_q[$].at + obs_q[$].lat + 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, spi_start, 1'b0);
    chk({tag, "_data"}, spi_data_in, 32'h0);
    chk({tag, "_chan"}, cmd_channel, 6'd0);
    chk({tag, "_conv"}, cmd_is_convert, 1'b0);
    chk({tag, "_busy"}, frame_busy, 1'b0);
    chk({tag, "_ovr"}, frame_overrun, 1'b0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    enable = 1'b1;
    cal_pend = 1'b1;

    // Basic frame, fixed latency 10 -> 13-cycle start spacing
    start_frame(1'b0, 6'd40);
    finish_frame();
    start_frame(1'b1, 6'd17);
    finish_frame();

    // Overrun: second tick 20 cycles in
    start_frame(1'b0, 6'd3);
    repeat (19) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("overrun_set", frame_overrun, 1'b1);
    finish_frame();
    repeat (5) @(negedge clk);
    chk("overrun_sticky", frame_overrun, 1'b1);

    // Same-cycle tick and clear while busy: set wins
    start_frame(1'b1, 6'd9);
    repeat (5) @(negedge clk);
    frame_tick = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    overrun_clr = 1'b0;
    chk("overrun_set_wins", frame_overrun, 1'b1);
    finish_frame();
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("overrun_cleared", frame_overrun, 1'b0);

    // Tick in the final-done cycle is an overrun
    start_frame(1'b0, 6'd21);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(spi_done && obs_q.size() == exp_len()) && n < 3000);
    chk("final_done_timeout", n < 3000, 1'b1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    finish_frame();
    repeat (6) @(negedge clk);
    chk("final_tick_no_start", obs_q.size(), exp_len());
    chk("final_tick_overrun", frame_overrun, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // Stray spi_done while idle is ignored
    obs_q.delete();
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_done_start", obs_q.size(), 0);
    chk("stray_done_busy", frame_busy, 1'b0);

    // Reset mid-frame after the 2nd start
    start_frame(1'b1, 6'd5);
    n = 0;
    while (obs_q.size() < 2 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("second_start_timeout", n < 500, 1'b1);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    cal_pend = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_quiet", obs_q.size(), 2);
    start_frame(1'b0, 6'd33);
    finish_frame();

    // Ticks with enable low are ignored
    enable = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (5) @(negedge clk);
    end
    chk("disabled_no_start", obs_q.size(), 0);
    chk("disabled_no_overrun", frame_overrun, 1'b0);
    enable = 1'b1;
    cal_pend = 1'b1;

    // Enable dropped mid-frame: frame completes, next tick ignored
    start_frame(1'b1, 6'd60);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    finish_frame();
    obs_q.delete();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    chk("dropped_enable_tick", obs_q.size(), 0);
    enable = 1'b1;
    cal_pend = 1'b1;

    // Randomized frames with random responder latency
    lat_fix = 0;
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(3, 0) == 0) begin
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        cal_pend = 1'b1;
      end
      start_frame(1'($urandom_range(1, 0)), 6'($urandom_range(63, 0)));
      finish_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
